// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the single write port of the async FIFO.
// Lives in the FIFO write-clock domain; one grantee at a time streams
// bursts of up to MAX_BURST beats, stalling while the FIFO is full.

// Per-requester slice: decides whether this lane owns the write port and
// masks its valid/last/data so the top level can OR-reduce across lanes.
module fifo_write_arbiter_lane #(
    parameter int DATA_WIDTH = 31,
    parameter int ID_WIDTH   = 2,
    parameter int LANE_ID    = 0
) (
    input  logic [ID_WIDTH-1:0]   grant_id,
    input  logic                  in_burst,
    input  logic                  write_ok,
    input  logic                  valid,
    input  logic                  last,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic                  sel_valid,
    output logic                  sel_last,
    output logic [DATA_WIDTH-1:0] sel_data
);

    logic sel;

    // Only the current grantee, and only while a burst is open, is selected.
    assign sel       = in_burst && (grant_id == ID_WIDTH'(LANE_ID));
    assign sel_valid = sel & valid;
    assign sel_last  = sel & last;
    assign sel_data  = sel ? data : '0;
    // write_ok folds in fifo_full and reset so ready never fires into a full FIFO.
    assign ready     = sel_valid & write_ok;

endmodule

module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 31,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy,
    output logic [15:0]                   write_count
);

    // Parameter sanity, caught at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("fifo_write_arbiter: NUM_REQ must be 2..16");
    end
    if (ID_WIDTH < $clog2(NUM_REQ)) begin : g_bad_id_width
        $error("fifo_write_arbiter: ID_WIDTH too narrow for NUM_REQ");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("fifo_write_arbiter: MAX_BURST must be 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [7:0]          BEAT_LAST  = 8'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0] LAST_RESET = ID_WIDTH'(NUM_REQ - 1);

    state_t                              state, state_nxt;
    logic [ID_WIDTH-1:0]                 last_grant, last_nxt, grant_nxt;
    logic [7:0]                          beat_cnt, beat_nxt;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  data_arr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  lane_data;
    logic [NUM_REQ-1:0]                  lane_valid;
    logic [NUM_REQ-1:0]                  lane_last;

    logic                                in_burst;
    logic                                write_ok;
    logic                                grant_valid;
    logic                                grant_last;
    logic                                acc;

    logic                                any_req;
    logic                                hi_any;
    logic [ID_WIDTH-1:0]                 hi_win, lo_win, winner;

    assign data_arr  = req_data;
    assign in_burst  = (state == BURST);
    // Reset suppresses the write in its own cycle, not just from the next one.
    assign write_ok  = ~fifo_full & ~reset;
    assign busy      = in_burst;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        fifo_write_arbiter_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ID_WIDTH   (ID_WIDTH),
            .LANE_ID    (i)
        ) u_lane (
            .grant_id  (grant_id),
            .in_burst  (in_burst),
            .write_ok  (write_ok),
            .valid     (req_valid[i]),
            .last      (req_last[i]),
            .data      (data_arr[i]),
            .ready     (req_ready[i]),
            .sel_valid (lane_valid[i]),
            .sel_last  (lane_last[i]),
            .sel_data  (lane_data[i])
        );
    end

    assign grant_valid = |lane_valid;
    assign grant_last  = |lane_last;
    assign acc         = grant_valid & write_ok;
    assign fifo_w_en   = acc;

    // Write data mux: at most one lane is selected, the rest contribute zero.
    always_comb begin
        fifo_w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_w_data = fifo_w_data | lane_data[i];
        end
    end

    // Round-robin pick: lowest requester above last_grant, else wrap to the
    // lowest requester overall. Descending scan leaves the lowest index.
    always_comb begin
        hi_any  = 1'b0;
        any_req = 1'b0;
        hi_win  = '0;
        lo_win  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_req = 1'b1;
                lo_win  = ID_WIDTH'(i);
                if (ID_WIDTH'(i) > last_grant) begin
                    hi_any = 1'b1;
                    hi_win = ID_WIDTH'(i);
                end
            end
        end
        winner = hi_any ? hi_win : lo_win;
    end

    // Next-state: grant from IDLE, then count beats until last/limit/release.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        last_nxt  = last_grant;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = BURST;
                    grant_nxt = winner;
                    last_nxt  = winner;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                // While full, everything holds and the burst resumes later.
                if (!fifo_full) begin
                    if (!grant_valid) begin
                        state_nxt = IDLE;
                    end else begin
                        beat_nxt = beat_cnt + 8'd1;
                        if (grant_last || beat_cnt == BEAT_LAST) begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant bookkeeping and the accepted-beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant_id    <= '0;
            last_grant  <= LAST_RESET;
            beat_cnt    <= '0;
            write_count <= '0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
            beat_cnt   <= beat_nxt;
            if (acc) begin
                write_count <= write_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: scenario tasks push expected
// beats, a negedge monitor pops and compares every FIFO write.
module tb_fifo_write_arbiter;

    localparam int DW = 31;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic              fifo_full = 1'b0;

    logic [NR-1:0]     req_ready;
    logic              fifo_w_en;
    logic [DW-1:0]     fifo_w_data;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic [15:0]       write_count;

    logic [NR-1:0]     w_req_ready;
    logic              w_fifo_w_en;
    logic [DW-1:0]     w_fifo_w_data;
    logic [IW-1:0]     w_grant_id;
    logic              w_busy;
    logic [15:0]       w_write_count;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         sb[$];
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b1;
    logic [NR-1:0] acc_mask = '0;
    int            cnt[NR];
    int            period[NR];
    int            mc[NR];

    fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_w_en(fifo_w_en), .fifo_w_data(fifo_w_data), .grant_id(grant_id),
        .busy(busy), .write_count(write_count)
    );

    // Long-burst instance so the 16-bit counter wrap is reachable quickly.
    fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW), .MAX_BURST(255)) dut_w (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(w_req_ready), .fifo_full(fifo_full),
        .fifo_w_en(w_fifo_w_en), .fifo_w_data(w_fifo_w_data), .grant_id(w_grant_id),
        .busy(w_busy), .write_count(w_write_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dval(input int i, input int k);
        return {4'(i), 27'(k)};
    endfunction

    // Requester models: data tracks each requester's accepted-beat count.
    always_comb begin
        req_data = '0;
        req_last = '0;
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = dval(i, cnt[i]);
            req_last[i] = (period[i] != 0) && ((cnt[i] % period[i]) == period[i] - 1);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (reset) cnt[i] <= 0;
            else if (acc_mask[i]) cnt[i] <= cnt[i] + 1;
        end
    end

    // Monitor: every FIFO write must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        beat_t e;
        acc_mask = req_ready;
        if (mon_en) begin
            checks++;
            if ((|req_ready) !== fifo_w_en || (fifo_w_en && fifo_full)) begin
                errors++;
                $display("FAIL mon_wen got w_en=%b ready=%b full=%b", fifo_w_en, req_ready, fifo_full);
            end
            if (fifo_w_en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got id=%0d data=%h exp none", grant_id, fifo_w_data);
                end else begin
                    e = sb.pop_front();
                    if (fifo_w_data !== e.data || grant_id !== e.id || req_ready !== (NR'(1) << e.id)) begin
                        errors++;
                        $display("FAIL sb_beat got id=%0d data=%h ready=%b exp id=%0d data=%h",
                                 grant_id, fifo_w_data, req_ready, e.id, e.data);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i);
        sb.push_back('{IW'(i), dval(i, mc[i])});
        mc[i]++;
    endtask

    task automatic apply_reset();
        next_cycle();
        reset = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            period[i] = 0;
            mc[i] = 0;
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b0 || fifo_w_en !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL rst_out got busy=%b w_en=%b ready=%b exp 0", busy, fifo_w_en, req_ready); end
        checks++; if (grant_id !== 2'd0 || write_count !== 16'd0) begin errors++; $display("FAIL rst_regs got gid=%0d wc=%0d exp 0", grant_id, write_count); end
        next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_hold got busy=%b exp 0", busy); end
        next_cycle();
        reset = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_rel got busy=%b exp 0", busy); end
    endtask

    task automatic test_single();
        apply_reset();
        req_valid = 4'b0001;
        period[0] = 3;
        for (int b = 0; b < 3; b++) push(0);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_arb got busy=%b exp 0", busy); end
        for (int b = 0; b < 3; b++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL t1_beat%0d got busy=%b gid=%0d exp 1/0", b, busy, grant_id); end
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || write_count !== 16'd3 || grant_id !== 2'd0) begin errors++; $display("FAIL t1_end got busy=%b wc=%0d gid=%0d exp 0/3/0", busy, write_count, grant_id); end
        next_cycle();
        period[0] = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || sb.size() != 0) begin errors++; $display("FAIL t1_drain got busy=%b sb=%0d exp 0/0", busy, sb.size()); end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) for (int b = 0; b < 4; b++) push(order[j]);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_arb got busy=%b exp 0", busy); end
        for (int j = 0; j < 5; j++) begin
            for (int b = 0; b < 4; b++) begin
                next_cycle();
                @(negedge clk);
                checks++; if (busy !== 1'b1 || grant_id !== IW'(order[j])) begin errors++; $display("FAIL rr_grant%0d got busy=%b gid=%0d exp 1/%0d", j, busy, grant_id, order[j]); end
            end
            next_cycle();
            if (j == 4) req_valid = '0;
            @(negedge clk);
            checks++; if (busy !== 1'b0 || fifo_w_en !== 1'b0) begin errors++; $display("FAIL rr_bubble%0d got busy=%b w_en=%b exp 0/0", j, busy, fifo_w_en); end
        end
        checks++; if (write_count !== 16'd20 || sb.size() != 0) begin errors++; $display("FAIL rr_total got wc=%0d sb=%0d exp 20/0", write_count, sb.size()); end
    endtask

    task automatic test_full_stall();
        apply_reset();
        req_valid = 4'b0100;
        for (int b = 0; b < 4; b++) push(2);
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL fs_pre%0d got busy=%b gid=%0d exp 1/2", b, busy, grant_id); end
        end
        for (int f = 0; f < 5; f++) begin
            next_cycle();
            fifo_full = 1'b1;
            @(negedge clk);
            checks++; if (busy !== 1'b1 || fifo_w_en !== 1'b0 || req_ready !== 4'b0 || grant_id !== 2'd2) begin errors++; $display("FAIL fs_stall%0d got busy=%b w_en=%b ready=%b gid=%0d exp 1/0/0/2", f, busy, fifo_w_en, req_ready, grant_id); end
        end
        for (int b = 0; b < 2; b++) begin
            next_cycle();
            fifo_full = 1'b0;
            @(negedge clk);
            checks++; if (busy !== 1'b1 || fifo_w_en !== 1'b1) begin errors++; $display("FAIL fs_resume%0d got busy=%b w_en=%b exp 1/1", b, busy, fifo_w_en); end
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || write_count !== 16'd4 || sb.size() != 0) begin errors++; $display("FAIL fs_end got busy=%b wc=%0d sb=%0d exp 0/4/0", busy, write_count, sb.size()); end
    endtask

    task automatic test_release();
        apply_reset();
        req_valid = 4'b0110;
        push(1); push(1);
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL rel_beat%0d got busy=%b gid=%0d exp 1/1", b, busy, grant_id); end
        end
        next_cycle();
        req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || fifo_w_en !== 1'b0) begin errors++; $display("FAIL rel_drop got busy=%b w_en=%b exp 1/0", busy, fifo_w_en); end
        next_cycle();
        req_valid = 4'b0110;
        for (int b = 0; b < 4; b++) push(2);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || grant_id !== 2'd1) begin errors++; $display("FAIL rel_idle got busy=%b gid=%0d exp 0/1", busy, grant_id); end
        for (int b = 0; b < 4; b++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL rel_next%0d got busy=%b gid=%0d exp 1/2", b, busy, grant_id); end
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || write_count !== 16'd6 || sb.size() != 0) begin errors++; $display("FAIL rel_end got busy=%b wc=%0d sb=%0d exp 0/6/0", busy, write_count, sb.size()); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_valid = 4'b0100;
        push(2); push(2);
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            next_cycle();
            @(negedge clk);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (fifo_w_en !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL rm_rstcyc got w_en=%b ready=%b exp 0/0", fifo_w_en, req_ready); end
        next_cycle();
        reset = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) mc[i] = 0;
        for (int b = 0; b < 4; b++) push(0);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || write_count !== 16'd0 || fifo_w_en !== 1'b0) begin errors++; $display("FAIL rm_after got busy=%b wc=%0d w_en=%b exp 0/0/0", busy, write_count, fifo_w_en); end
        for (int b = 0; b < 4; b++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL rm_grant%0d got busy=%b gid=%0d exp 1/0", b, busy, grant_id); end
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || write_count !== 16'd4 || sb.size() != 0) begin errors++; $display("FAIL rm_end got busy=%b wc=%0d sb=%0d exp 0/4/0", busy, write_count, sb.size()); end
    endtask

    task automatic test_full_idle();
        apply_reset();
        req_valid = 4'b0001;
        fifo_full = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fi_idle got busy=%b exp 0", busy); end
        next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_w_en !== 1'b0) begin errors++; $display("FAIL fi_grant got busy=%b gid=%0d w_en=%b exp 1/0/0", busy, grant_id, fifo_w_en); end
        for (int b = 0; b < 4; b++) begin
            next_cycle();
            if (b == 0) begin
                fifo_full = 1'b0;
                for (int k = 0; k < 4; k++) push(0);
            end
            @(negedge clk);
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || write_count !== 16'd4 || sb.size() != 0) begin errors++; $display("FAIL fi_end got busy=%b wc=%0d sb=%0d exp 0/4/0", busy, write_count, sb.size()); end
    endtask

    // 257 bursts of 255 beats, one bubble each: 65535 beats after 257*256 cycles.
    task automatic test_wrap();
        mon_en = 1'b0;
        apply_reset();
        req_valid = 4'b0001;
        for (int c = 1; c <= 65795; c++) begin
            if (c > 1) next_cycle();
            @(negedge clk);
            if (c == 257) begin
                checks++; if (w_write_count !== 16'd255 || w_busy !== 1'b0) begin errors++; $display("FAIL wr_first got wc=%0d busy=%b exp 255/0", w_write_count, w_busy); end
            end
            if (c == 65793) begin
                checks++; if (w_write_count !== 16'hFFFF || w_busy !== 1'b0) begin errors++; $display("FAIL wr_max got wc=%0d busy=%b exp 65535/0", w_write_count, w_busy); end
            end
            if (c == 65794) begin
                checks++; if (w_busy !== 1'b1 || w_fifo_w_en !== 1'b1 || w_req_ready !== 4'b0001 || w_grant_id !== 2'd0 || w_fifo_w_data !== req_data[DW-1:0]) begin errors++; $display("FAIL wr_beat got busy=%b w_en=%b ready=%b gid=%0d data=%h exp 1/1/0001/0/%h", w_busy, w_fifo_w_en, w_req_ready, w_grant_id, w_fifo_w_data, req_data[DW-1:0]); end
            end
            if (c == 65795) begin
                checks++; if (w_write_count !== 16'd0) begin errors++; $display("FAIL wr_wrap got wc=%0d exp 0", w_write_count); end
            end
        end
        req_valid = '0;
        apply_reset();
        sb.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_release();
        test_reset_mid();
        test_full_idle();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
